// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, requests words over req/ack and
// buffers {pc, inst} in a prefetch queue. Optional counters: FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd100,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req_c,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_if_valid,
    output logic [31:0] o_if_inst,
    output logic [31:0] o_if_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_discard_cnt,
`endif
    output logic [31:0] o_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_addr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic          r_if_valid;
    logic [31:0]   r_if_inst;
    logic [31:0]   r_if_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   r_fetch_cnt;
    logic [31:0]   r_discard_cnt;
`endif

    state_t        w_state_nxt;
    logic          w_req;
    logic          w_xfer;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_flush;
    logic [31:0]   w_redirect_pc;
    logic [31:0]   w_pc_nxt;
    logic [31:0]   w_addr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] w_rd_nxt;
    logic [PW-1:0] w_wr_nxt;
    logic          w_head_valid;
    logic [31:0]   w_head_inst;
    logic [31:0]   w_head_pc;

    // Request depends only on state and occupancy; held low during reset.
    assign w_req         = rst_n && ((r_state == ST_DISCARD) || (r_count < CW'(DEPTH)));
    assign w_xfer        = w_req && i_imem_ack;
    assign w_redirect_pc = i_redirect_pc & ~32'h3;

    // Next-state, queue bookkeeping and next queue head.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_drop       = 1'b0;
        w_flush      = 1'b0;
        w_head_valid = 1'b0;
        w_head_inst  = 32'h0;
        w_head_pc    = 32'h0;

        case (r_state)
            ST_FETCH: begin
                if (i_redirect) begin
                    w_flush  = 1'b1;
                    w_drop   = w_xfer;
                    w_pc_nxt = w_redirect_pc;
                    if (w_req && !i_imem_ack) begin
                        w_state_nxt = ST_DISCARD;
                    end
                end else begin
                    w_push = w_xfer;
                    w_pop  = r_if_valid && !i_stall;
                    if (w_xfer) begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
            end
            ST_DISCARD: begin
                w_drop = w_xfer;
                w_pop  = r_if_valid && !i_stall && !i_redirect;
                if (w_xfer) begin
                    w_state_nxt = ST_FETCH;
                end
                if (i_redirect) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = w_redirect_pc;
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase

        if (w_flush) begin
            w_rd_nxt    = '0;
            w_wr_nxt    = '0;
            w_count_nxt = '0;
        end else begin
            w_rd_nxt    = r_rd + PW'(w_pop);
            w_wr_nxt    = r_wr + PW'(w_push);
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        end

        // Old address stays on the bus until the abandoned request is acked.
        w_addr_nxt = (w_state_nxt == ST_DISCARD) ? r_addr : w_pc_nxt;

        if (w_count_nxt != '0) begin
            w_head_valid = 1'b1;
            if (w_push && (r_wr == w_rd_nxt)) begin
                w_head_inst = i_imem_rdata;
                w_head_pc   = r_pc;
            end else begin
                w_head_inst = r_mem_inst[w_rd_nxt];
                w_head_pc   = r_mem_pc[w_rd_nxt];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_addr        <= RESET_PC;
            r_count       <= '0;
            r_rd          <= '0;
            r_wr          <= '0;
            r_if_valid    <= 1'b0;
            r_if_inst     <= 32'h0;
            r_if_pc       <= 32'h0;
`ifdef FETCH_PERF_CNT_EN
            r_fetch_cnt   <= 32'h0;
            r_discard_cnt <= 32'h0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_addr        <= w_addr_nxt;
            r_count       <= w_count_nxt;
            r_rd          <= w_rd_nxt;
            r_wr          <= w_wr_nxt;
            r_if_valid    <= w_head_valid;
            r_if_inst     <= w_head_inst;
            r_if_pc       <= w_head_pc;
`ifdef FETCH_PERF_CNT_EN
            r_fetch_cnt   <= r_fetch_cnt + 32'(w_push);
            r_discard_cnt <= r_discard_cnt + 32'(w_drop);
`endif
        end
    end

    // Queue storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr] <= i_imem_rdata;
            r_mem_pc[r_wr]   <= r_pc;
        end
    end

    assign o_imem_req_c  = w_req;
    assign o_imem_addr   = r_addr;
    assign o_if_valid    = r_if_valid;
    assign o_if_inst     = r_if_inst;
    assign o_if_pc       = r_if_pc;
    assign o_pc          = r_pc;
`ifdef FETCH_PERF_CNT_EN
    assign o_fetch_cnt   = r_fetch_cnt;
    assign o_discard_cnt = r_discard_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// scored against a program-order queue model. Honours FETCH_PERF_CNT_EN.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'd100;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_imem_req_c;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b1;
    logic [31:0] i_imem_rdata;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_if_valid;
    logic [31:0] o_if_inst;
    logic [31:0] o_if_pc;
    logic [31:0] o_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_discard_cnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] salt = 32'h0;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_imem_req_c  (o_imem_req_c),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_if_valid    (o_if_valid),
        .o_if_inst     (o_if_inst),
        .o_if_pc       (o_if_pc),
`ifdef FETCH_PERF_CNT_EN
        .o_fetch_cnt   (o_fetch_cnt),
        .o_discard_cnt (o_discard_cnt),
`endif
        .o_pc          (o_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1 ^ salt;
    endfunction

    always_comb i_imem_rdata = {o_imem_addr[15:0], o_imem_addr[31:16]} ^ 32'h5A3C_96E1 ^ salt;

    // Memory responder: 0 = ack tied high, 1 = fixed latency, 2 = random ack.
    int ack_mode = 0;
    int ack_lat  = 3;
    int wait_cnt = 0;
    logic resp_xs, resp_rs;
    always begin
        @(negedge clk);
        resp_xs = o_imem_req_c && i_imem_ack;
        resp_rs = o_imem_req_c;
        @(posedge clk);
        #2;
        if (!rst_n || resp_xs) wait_cnt = 0;
        else if (resp_rs) wait_cnt++;
        case (ack_mode)
            0:       i_imem_ack = 1'b1;
            1:       i_imem_ack = (wait_cnt >= ack_lat - 1);
            default: i_imem_ack = ($urandom_range(0, 2) == 0);
        endcase
    end

    // Reference model: in-order queue of fetched PCs since the last redirect.
    logic [31:0] m_q[$];
    logic [31:0] m_fpc = RST_PC;
    logic [31:0] m_held = RST_PC;
    bit          m_pend = 1'b0;
    int unsigned m_fetch = 0;
    int unsigned m_disc = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_fpc   = RST_PC;
            m_pend  = 1'b0;
            m_fetch = 0;
            m_disc  = 0;
        end else begin
            logic exp_req, xfer;
            exp_req = m_pend || (m_q.size() < DEPTH);
            n_cmp++;
            if (o_imem_req_c !== exp_req) begin
                n_err++;
                if (n_err < 20) $display("FAIL sb_req t=%0t got %b want %b", $time, o_imem_req_c, exp_req);
            end
            if (exp_req) begin
                n_cmp++;
                if (o_imem_addr !== (m_pend ? m_held : m_fpc)) begin
                    n_err++;
                    if (n_err < 20) $display("FAIL sb_addr t=%0t got %h want %h", $time, o_imem_addr, m_pend ? m_held : m_fpc);
                end
            end
            n_cmp++;
            if (o_pc !== m_fpc) begin
                n_err++;
                if (n_err < 20) $display("FAIL sb_pc t=%0t got %h want %h", $time, o_pc, m_fpc);
            end
            n_cmp++;
            if (o_if_valid !== (m_q.size() != 0)) begin
                n_err++;
                if (n_err < 20) $display("FAIL sb_valid t=%0t got %b want %b", $time, o_if_valid, m_q.size() != 0);
            end
            n_cmp++;
            if (m_q.size() != 0) begin
                if (o_if_pc !== m_q[0] || o_if_inst !== mem_word(m_q[0])) begin
                    n_err++;
                    if (n_err < 20) $display("FAIL sb_head t=%0t got pc %h inst %h want pc %h inst %h",
                                             $time, o_if_pc, o_if_inst, m_q[0], mem_word(m_q[0]));
                end
            end else if (o_if_pc !== 32'h0 || o_if_inst !== 32'h0) begin
                n_err++;
                if (n_err < 20) $display("FAIL sb_nop t=%0t got pc %h inst %h want 0", $time, o_if_pc, o_if_inst);
            end
`ifdef FETCH_PERF_CNT_EN
            n_cmp++;
            if (o_fetch_cnt !== m_fetch || o_discard_cnt !== m_disc) begin
                n_err++;
                if (n_err < 20) $display("FAIL sb_cnt t=%0t got %0d/%0d want %0d/%0d",
                                         $time, o_fetch_cnt, o_discard_cnt, m_fetch, m_disc);
            end
`endif
            xfer = o_imem_req_c && i_imem_ack;
            if (i_redirect) begin
                if (xfer) m_disc++;
                m_pend = o_imem_req_c && !i_imem_ack;
                m_held = o_imem_addr;
                m_q.delete();
                m_fpc = i_redirect_pc & ~32'h3;
            end else begin
                if (m_q.size() != 0 && !i_stall) void'(m_q.pop_front());
                if (xfer) begin
                    if (m_pend) begin
                        m_pend = 1'b0;
                        m_disc++;
                    end else begin
                        m_q.push_back(m_fpc);
                        m_fpc = m_fpc + 32'd4;
                        m_fetch++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n      = 1'b0;
        i_stall    = 1'b0;
        i_redirect = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ack_mode = 0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_imem_req_c !== 1'b0 || o_if_valid !== 1'b0 || o_if_inst !== 32'h0 ||
            o_if_pc !== 32'h0 || o_pc !== RST_PC) begin
            n_err++;
            $display("FAIL reset_vals req %b valid %b inst %h ifpc %h pc %h want 0 0 0 0 %h",
                     o_imem_req_c, o_if_valid, o_if_inst, o_if_pc, o_pc, RST_PC);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_cmp++;
        if (o_imem_req_c !== 1'b1 || o_imem_addr !== RST_PC) begin
            n_err++;
            $display("FAIL first_req got req %b addr %h want 1 %h", o_imem_req_c, o_imem_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        ack_mode = 0;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (o_imem_addr !== RST_PC + 32'(4 * (k - 1))) begin
                n_err++;
                $display("FAIL stream_addr cyc %0d got %h want %h", k, o_imem_addr, RST_PC + 32'(4 * (k - 1)));
            end
            if (k >= 2) begin
                n_cmp++;
                if (o_if_valid !== 1'b1 || o_if_pc !== RST_PC + 32'(4 * (k - 2)) ||
                    o_if_inst !== mem_word(RST_PC + 32'(4 * (k - 2)))) begin
                    n_err++;
                    $display("FAIL stream_head cyc %0d got %b %h %h want pc %h", k, o_if_valid, o_if_pc,
                             o_if_inst, RST_PC + 32'(4 * (k - 2)));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] p;
        @(posedge clk);
        #1 i_stall = 1'b1;
        p = o_if_pc;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            n_cmp++;
            if (o_if_valid !== 1'b1 || o_if_pc !== p) begin
                n_err++;
                $display("FAIL stall_hold cyc %0d got %b %h want 1 %h", j, o_if_valid, o_if_pc, p);
            end
            if (j >= 1) begin
                n_cmp++;
                if (o_imem_req_c !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_full_req cyc %0d got %b want 0", j, o_imem_req_c);
                end
            end
        end
        @(posedge clk);
        #1 i_stall = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            n_cmp++;
            if (o_if_valid !== 1'b1 || o_if_pc !== p + 32'(4 * j)) begin
                n_err++;
                $display("FAIL stall_resume cyc %0d got %b %h want 1 %h", j, o_if_valid, o_if_pc, p + 32'(4 * j));
            end
        end
    endtask

    task automatic test_latency();
        logic exp_v;
        ack_mode = 1;
        ack_lat  = 3;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if (o_imem_req_c !== 1'b1 || o_imem_addr !== RST_PC + 32'(4 * ((k - 1) / 3))) begin
                n_err++;
                $display("FAIL lat_addr cyc %0d got %b %h want 1 %h", k, o_imem_req_c, o_imem_addr,
                         RST_PC + 32'(4 * ((k - 1) / 3)));
            end
            exp_v = (k >= 4) && (k % 3 == 1);
            n_cmp++;
            if (o_if_valid !== exp_v || (exp_v && o_if_pc !== RST_PC + 32'(4 * ((k - 4) / 3)))) begin
                n_err++;
                $display("FAIL lat_head cyc %0d got %b %h want %b %h", k, o_if_valid, o_if_pc, exp_v,
                         RST_PC + 32'(4 * ((k - 4) / 3)));
            end
        end
    endtask

    task automatic test_redirect_ack();
        bit found = 1'b0;
        ack_mode = 0;
        do_reset();
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1;
            if (o_imem_addr === 32'h10C) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL redir_ack_reach got addr %h want 0000010c", o_imem_addr);
            return;
        end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        @(posedge clk);
        #1 i_redirect = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_if_valid !== 1'b0 || o_imem_req_c !== 1'b1 || o_imem_addr !== 32'h200) begin
            n_err++;
            $display("FAIL redir_ack_next got valid %b req %b addr %h want 0 1 00000200",
                     o_if_valid, o_imem_req_c, o_imem_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (o_discard_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL redir_ack_disc got %0d want 1", o_discard_cnt);
        end
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (o_if_valid !== 1'b1 || o_if_pc !== 32'h200 + 32'(4 * k)) begin
                n_err++;
                $display("FAIL redir_ack_head cyc %0d got %b %h want 1 %h", k, o_if_valid, o_if_pc,
                         32'h200 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect_pending();
        ack_mode = 1;
        ack_lat  = 3;
        do_reset();
        @(negedge clk);
        @(posedge clk);
        #1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h303;
        @(posedge clk);
        #1 i_redirect = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_imem_req_c !== 1'b1 || o_imem_addr !== RST_PC || o_if_valid !== 1'b0 || o_pc !== 32'h300) begin
            n_err++;
            $display("FAIL disc_hold got req %b addr %h valid %b pc %h want 1 %h 0 00000300",
                     o_imem_req_c, o_imem_addr, o_if_valid, o_pc, RST_PC);
        end
        for (int k = 4; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (o_imem_addr !== 32'h300 || o_if_valid !== 1'b0) begin
                n_err++;
                $display("FAIL disc_new cyc %0d got addr %h valid %b want 00000300 0", k, o_imem_addr, o_if_valid);
            end
`ifdef FETCH_PERF_CNT_EN
            n_cmp++;
            if (o_discard_cnt !== 32'd1) begin
                n_err++;
                $display("FAIL disc_cnt cyc %0d got %0d want 1", k, o_discard_cnt);
            end
`endif
        end
        @(negedge clk);
        n_cmp++;
        if (o_if_valid !== 1'b1 || o_if_pc !== 32'h300 || o_if_inst !== mem_word(32'h300)) begin
            n_err++;
            $display("FAIL disc_head got %b %h %h want 1 00000300 %h", o_if_valid, o_if_pc, o_if_inst,
                     mem_word(32'h300));
        end
    endtask

    task automatic test_reset_midflight();
        ack_mode = 1;
        ack_lat  = 3;
        do_reset();
        i_stall = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3;
        n_cmp++;
        if (o_if_valid !== 1'b1 || o_imem_req_c !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre got valid %b req %b want 1 1", o_if_valid, o_imem_req_c);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_if_valid !== 1'b0 || o_if_inst !== 32'h0 || o_if_pc !== 32'h0 ||
            o_imem_req_c !== 1'b0 || o_pc !== RST_PC) begin
            n_err++;
            $display("FAIL mid_async got valid %b inst %h ifpc %h req %b pc %h want 0 0 0 0 %h",
                     o_if_valid, o_if_inst, o_if_pc, o_imem_req_c, o_pc, RST_PC);
        end
        i_stall = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_cmp++;
        if (o_imem_req_c !== 1'b1 || o_imem_addr !== RST_PC) begin
            n_err++;
            $display("FAIL mid_restart got req %b addr %h want 1 %h", o_imem_req_c, o_imem_addr, RST_PC);
        end
    endtask

    task automatic test_random();
        ack_mode = 2;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            i_stall    = ($urandom_range(0, 9) < 3);
            i_redirect = ($urandom_range(0, 19) == 0);
            i_redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF5 : $urandom;
        end
        i_redirect = 1'b0;
        i_stall    = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_stream();
        test_stall();
        test_latency();
        test_redirect_ack();
        test_redirect_pending();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

endmodule
